// File: rtl/instr_decode_if.sv
// instr_decode_if: fetch-side and downstream-side handshake bundle of the decode stage.
interface instr_decode_if #(
    parameter int CNT_W = 8
) ();
    logic             in_valid;
    logic [15:0]      in_instr;
    logic             in_ready;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_opcode;
    logic [2:0]       out_rd;
    logic [2:0]       out_rs;
    logic [2:0]       out_rt;
    logic [4:0]       out_imm5;
    logic             out_is_itype;
    logic             out_illegal;
    logic [CNT_W-1:0] decoded_count;

    modport slave (
        input  in_valid, in_instr, flush, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_imm5, out_is_itype, out_illegal, decoded_count
    );

    modport master (
        output in_valid, in_instr, flush, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs, out_rt,
               out_imm5, out_is_itype, out_illegal, decoded_count
    );
endinterface

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: two-entry (main + skid) decode stage with delivered-instruction counter.
// Define DECODE_ILLEGAL_TRAP_EN to trap opcodes E/F in main until flush.
module instr_decode_stage #(
    parameter int         CNT_W      = 8,
    parameter logic [3:0] ITYPE_MASK = 4'b1000
) (
    input logic           clk,
    input logic           rst_n,
    instr_decode_if.slave bus
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
    state_e           state_q, state_d;
    logic [15:0]      main_q, main_d, skid_q, skid_d;
    logic             in_ready_q, out_valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic             illegal, accept, pop;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign illegal = out_valid_q && (main_q[15:13] == 3'b111);
`else
    assign illegal = 1'b0;
`endif
    assign accept = bus.in_valid && in_ready_q;
    assign pop    = out_valid_q && bus.out_ready && !illegal;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (bus.flush) state_d = EMPTY;
        else case (state_q)
            EMPTY: if (accept) begin
                main_d  = bus.in_instr;
                state_d = ONE;
            end
            ONE: if (accept && pop) main_d = bus.in_instr;
                else if (accept) begin
                    skid_d  = bus.in_instr;
                    state_d = TWO;
                end else if (pop) state_d = EMPTY;
            TWO: if (pop) begin
                main_d  = skid_q;
                state_d = ONE;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= state_d != TWO;
            out_valid_q <= state_d != EMPTY;
            cnt_q       <= cnt_q + CNT_W'(pop);
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_opcode    = main_q[15:12];
    assign bus.out_rd        = main_q[11:9];
    assign bus.out_rs        = main_q[8:6];
    assign bus.out_rt        = main_q[5:3];
    assign bus.out_imm5      = main_q[4:0];
    assign bus.out_is_itype  = (main_q[15:12] & ITYPE_MASK) != 4'b0000;
    assign bus.out_illegal   = illegal;
    assign bus.decoded_count = cnt_q;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed checks of the decode stage handshake, decode fields and counter.
module tb_instr_decode_stage;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_fail = 0;

    instr_decode_if #(.CNT_W(8)) bus ();

    instr_decode_stage #(.CNT_W(8), .ITYPE_MASK(4'b1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 16'h0000;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ready", bus.in_ready, 0);
        chk("rst_cnt", bus.decoded_count, 0);
        chk("rst_opcode", bus.out_opcode, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rel_ready", bus.in_ready, 1);
        chk("rel_valid", bus.out_valid, 0);

        // First instruction: one-cycle latency, full field decode
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h8A53;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("d_valid", bus.out_valid, 1);
        chk("d_opcode", bus.out_opcode, 8);
        chk("d_rd", bus.out_rd, 5);
        chk("d_rs", bus.out_rs, 1);
        chk("d_rt", bus.out_rt, 2);
        chk("d_imm5", bus.out_imm5, 5'h13);
        chk("d_itype", bus.out_is_itype, 1);
        chk("d_illegal", bus.out_illegal, 0);
        chk("d_cnt0", bus.decoded_count, 0);
        step();
        chk("d_cnt1", bus.decoded_count, 1);
        chk("d_empty", bus.out_valid, 0);

        // Fill both entries, hold under backpressure, then drain in order
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h1111;
        step();
        bus.in_instr = 16'h2222;
        step();
        bus.in_valid = 1'b0;
        chk("two_ready", bus.in_ready, 0);
        chk("two_valid", bus.out_valid, 1);
        chk("two_opcode", bus.out_opcode, 1);
        chk("two_rs", bus.out_rs, 4);
        chk("two_imm5", bus.out_imm5, 5'h11);
        chk("two_itype", bus.out_is_itype, 0);
        step();
        chk("hold_opcode", bus.out_opcode, 1);
        chk("hold_imm5", bus.out_imm5, 5'h11);
        chk("hold_valid", bus.out_valid, 1);
        bus.out_ready = 1'b1;
        step();
        chk("drain_opcode", bus.out_opcode, 2);
        chk("drain_rd", bus.out_rd, 1);
        chk("drain_rt", bus.out_rt, 4);
        chk("drain_ready", bus.in_ready, 1);
        chk("drain_cnt", bus.decoded_count, 2);
        step();
        chk("drain_empty", bus.out_valid, 0);
        chk("drain_cnt2", bus.decoded_count, 3);

        // Same-cycle accept and pop in ONE
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h4444;
        step();
        chk("one_opcode", bus.out_opcode, 4);
        bus.in_instr = 16'h3333;
        step();
        bus.in_valid = 1'b0;
        chk("ap_opcode", bus.out_opcode, 3);
        chk("ap_valid", bus.out_valid, 1);
        chk("ap_ready", bus.in_ready, 1);
        chk("ap_cnt", bus.decoded_count, 4);
        step();
        chk("ap_cnt2", bus.decoded_count, 5);

        // Flush from TWO with a word offered
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'h5555;
        step();
        bus.in_instr = 16'h6666;
        step();
        chk("fl_two_ready", bus.in_ready, 0);
        bus.flush    = 1'b1;
        bus.in_instr = 16'h7777;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_ready", bus.in_ready, 1);
        chk("fl_cnt", bus.decoded_count, 5);
        step();
        chk("fl_absent", bus.out_valid, 0);

        // Flush discards a same-cycle accept from EMPTY
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h7777;
        bus.flush    = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("fla_valid", bus.out_valid, 0);
        step();
        chk("fla_absent", bus.out_valid, 0);

        // Flush with a same-cycle pop still counts the pop
        bus.in_valid = 1'b1;
        bus.in_instr = 16'h1234;
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("flp_valid", bus.out_valid, 0);
        chk("flp_cnt", bus.decoded_count, 6);

        // Opcode F: trapped when the macro is defined, flows otherwise
        bus.in_valid = 1'b1;
        bus.in_instr = 16'hF000;
        step();
        bus.in_valid = 1'b0;
        chk("ill_opcode", bus.out_opcode, 4'hF);
        chk("ill_valid", bus.out_valid, 1);
`ifdef DECODE_ILLEGAL_TRAP_EN
        chk("ill_flag", bus.out_illegal, 1);
        step();
        chk("ill_hold_valid", bus.out_valid, 1);
        chk("ill_hold_flag", bus.out_illegal, 1);
        chk("ill_hold_cnt", bus.decoded_count, 6);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("ill_fl_valid", bus.out_valid, 0);
        chk("ill_fl_cnt", bus.decoded_count, 6);
`else
        chk("ill_flag", bus.out_illegal, 0);
        step();
        chk("ill_pop_valid", bus.out_valid, 0);
        chk("ill_pop_cnt", bus.decoded_count, 7);
`endif

        // Reset mid-transfer discards held word immediately
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 16'hABCD;
        step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", bus.out_valid, 0);
        chk("mr_ready", bus.in_ready, 0);
        chk("mr_cnt", bus.decoded_count, 0);
        chk("mr_opcode", bus.out_opcode, 0);
        #2;
        rst_n = 1'b1;
        step();
        chk("mr_rel_valid", bus.out_valid, 0);
        chk("mr_rel_ready", bus.in_ready, 1);

        // 257 deliveries wrap the 8-bit counter to 1
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 257; i++) begin
            bus.in_instr = 16'(i);
            step();
        end
        bus.in_valid = 1'b0;
        chk("wrap_cnt0", bus.decoded_count, 0);
        chk("wrap_last", bus.out_rs, 3'd4);
        step();
        chk("wrap_cnt1", bus.decoded_count, 1);
        chk("wrap_empty", bus.out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
